// File: rtl/regblock_adapter.sv
// CTRL/STATUS/CNT/INTR register block behind a 32-bit pass-through CPU port.
// Optional storage parity check: define REGBLOCK_PARITYCHECK_EN.
module regblock_adapter #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 4,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_cpuif_req,
  input  logic              s_cpuif_req_is_wr,
  input  logic [ADDR_W-1:0] s_cpuif_addr,
  input  logic [DATA_W-1:0] s_cpuif_wr_data,
  input  logic [DATA_W-1:0] s_cpuif_wr_biten,
  output logic              s_cpuif_req_stall_wr,
  output logic              s_cpuif_req_stall_rd,
  output logic              s_cpuif_rd_ack,
  output logic              s_cpuif_rd_err,
  output logic [DATA_W-1:0] s_cpuif_rd_data,
  output logic              s_cpuif_wr_ack,
  output logic              s_cpuif_wr_err,
  input  logic [31:0]       hwif_in_status,
  input  logic              hwif_in_cnt_incr,
  input  logic [7:0]        hwif_in_intr_set,
  output logic [31:0]       hwif_out_ctrl,
  output logic [15:0]       hwif_out_cnt,
  output logic              hwif_out_irq,
  output logic              parity_error
);

  logic [31:0] ctrl_q, ctrl_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic [7:0]  intr_q, intr_nxt, intr_clr;
  logic [31:0] rd_mux;
  logic [31:0] rd_data_q;
  logic        rd_ack_q, wr_ack_q, wr_err_q;

  logic [1:0] widx;
  logic       sel_ctrl, sel_stat, sel_cnt, sel_intr;
  logic       wr_en, rd_en;
  logic       ctrl_we, cnt_we, intr_we;
  logic       unused_addr;

  assign widx        = s_cpuif_addr[3:2];
  assign unused_addr = ^s_cpuif_addr[1:0];
  assign sel_ctrl    = (widx == 2'd0);
  assign sel_stat    = (widx == 2'd1);
  assign sel_cnt     = (widx == 2'd2);
  assign sel_intr    = (widx == 2'd3);
  assign wr_en       = s_cpuif_req & s_cpuif_req_is_wr;
  assign rd_en       = s_cpuif_req & ~s_cpuif_req_is_wr;

  assign ctrl_we = wr_en & sel_ctrl;
  assign cnt_we  = (wr_en & sel_cnt) | hwif_in_cnt_incr;
  assign intr_we = (wr_en & sel_intr) | (|hwif_in_intr_set);

  always_comb begin
    ctrl_nxt = ctrl_q;
    if (ctrl_we)
      ctrl_nxt = (ctrl_q & ~s_cpuif_wr_biten)
               | (s_cpuif_wr_data & s_cpuif_wr_biten);
    // a software write takes priority over a same-cycle increment
    cnt_nxt = cnt_q;
    if (wr_en && sel_cnt)
      cnt_nxt = (cnt_q & ~s_cpuif_wr_biten[15:0])
              | (s_cpuif_wr_data[15:0] & s_cpuif_wr_biten[15:0]);
    else if (hwif_in_cnt_incr)
      cnt_nxt = cnt_q + 16'd1;
    intr_clr = '0;
    if (wr_en && sel_intr)
      intr_clr = s_cpuif_wr_data[7:0] & s_cpuif_wr_biten[7:0];
    // OR-ing the set term last makes a set beat a same-cycle clear
    intr_nxt = (intr_q & ~intr_clr) | hwif_in_intr_set;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl: rd_mux = ctrl_q;
      sel_stat: rd_mux = hwif_in_status;
      sel_cnt:  rd_mux = {16'h0, cnt_q};
      sel_intr: rd_mux = {24'h0, intr_q};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= CTRL_RESET;
      cnt_q     <= '0;
      intr_q    <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ctrl_q    <= ctrl_nxt;
      cnt_q     <= cnt_nxt;
      intr_q    <= intr_nxt;
      rd_ack_q  <= rd_en;
      wr_ack_q  <= wr_en;
      wr_err_q  <= wr_en & sel_stat;
      rd_data_q <= rd_en ? rd_mux : '0;
    end
  end

`ifdef REGBLOCK_PARITYCHECK_EN
  logic ctrl_p_q, cnt_p_q, intr_p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_p_q <= ^CTRL_RESET;
      cnt_p_q  <= 1'b0;
      intr_p_q <= 1'b0;
    end else begin
      if (ctrl_we) ctrl_p_q <= ^ctrl_nxt;
      if (cnt_we)  cnt_p_q  <= ^cnt_nxt;
      if (intr_we) intr_p_q <= ^intr_nxt;
    end
  end

  assign parity_error = (^ctrl_q ^ ctrl_p_q)
                      | (^cnt_q  ^ cnt_p_q)
                      | (^intr_q ^ intr_p_q);
`else
  logic unused_we;
  assign unused_we    = ctrl_we ^ cnt_we ^ intr_we;
  assign parity_error = 1'b0;
`endif

  assign s_cpuif_req_stall_wr = 1'b0;
  assign s_cpuif_req_stall_rd = 1'b0;
  assign s_cpuif_rd_ack       = rd_ack_q;
  assign s_cpuif_rd_err       = 1'b0;
  assign s_cpuif_rd_data      = rd_data_q;
  assign s_cpuif_wr_ack       = wr_ack_q;
  assign s_cpuif_wr_err       = wr_err_q;
  assign hwif_out_ctrl        = ctrl_q;
  assign hwif_out_cnt         = cnt_q;
  assign hwif_out_irq         = |(intr_q & ctrl_q[7:0]);

endmodule

// File: tb/tb_regblock_adapter.sv
// Directed bench for regblock_adapter with a response scoreboard.
// Parity steps are built only when REGBLOCK_PARITYCHECK_EN is defined.
module tb_regblock_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cpuif_req;
  logic        s_cpuif_req_is_wr;
  logic [3:0]  s_cpuif_addr;
  logic [31:0] s_cpuif_wr_data;
  logic [31:0] s_cpuif_wr_biten;
  logic        s_cpuif_req_stall_wr;
  logic        s_cpuif_req_stall_rd;
  logic        s_cpuif_rd_ack;
  logic        s_cpuif_rd_err;
  logic [31:0] s_cpuif_rd_data;
  logic        s_cpuif_wr_ack;
  logic        s_cpuif_wr_err;
  logic [31:0] hwif_in_status;
  logic        hwif_in_cnt_incr;
  logic [7:0]  hwif_in_intr_set;
  logic [31:0] hwif_out_ctrl;
  logic [15:0] hwif_out_cnt;
  logic        hwif_out_irq;
  logic        parity_error;

  regblock_adapter dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_cpuif_req          (s_cpuif_req),
    .s_cpuif_req_is_wr    (s_cpuif_req_is_wr),
    .s_cpuif_addr         (s_cpuif_addr),
    .s_cpuif_wr_data      (s_cpuif_wr_data),
    .s_cpuif_wr_biten     (s_cpuif_wr_biten),
    .s_cpuif_req_stall_wr (s_cpuif_req_stall_wr),
    .s_cpuif_req_stall_rd (s_cpuif_req_stall_rd),
    .s_cpuif_rd_ack       (s_cpuif_rd_ack),
    .s_cpuif_rd_err       (s_cpuif_rd_err),
    .s_cpuif_rd_data      (s_cpuif_rd_data),
    .s_cpuif_wr_ack       (s_cpuif_wr_ack),
    .s_cpuif_wr_err       (s_cpuif_wr_err),
    .hwif_in_status       (hwif_in_status),
    .hwif_in_cnt_incr     (hwif_in_cnt_incr),
    .hwif_in_intr_set     (hwif_in_intr_set),
    .hwif_out_ctrl        (hwif_out_ctrl),
    .hwif_out_cnt         (hwif_out_cnt),
    .hwif_out_irq         (hwif_out_irq),
    .parity_error         (parity_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
    logic        err;
    int          due;
  } rsp_t;

  rsp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  bit   armed = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [31:0] be, input logic err);
    s_cpuif_req       = 1'b1;
    s_cpuif_req_is_wr = 1'b1;
    s_cpuif_addr      = a;
    s_cpuif_wr_data   = d;
    s_cpuif_wr_biten  = be;
    sbq.push_back('{1'b1, 32'h0, err, cycle + 1});
    tick();
    s_cpuif_req       = 1'b0;
    s_cpuif_req_is_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    s_cpuif_req       = 1'b1;
    s_cpuif_req_is_wr = 1'b0;
    s_cpuif_addr      = a;
    sbq.push_back('{1'b0, exp, 1'b0, cycle + 1});
    tick();
    s_cpuif_req       = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    rsp_t r;
    if (armed) begin
      if (sbq.size() > 0 && sbq[0].due == cycle) begin
        r = sbq.pop_front();
        if (r.is_wr) begin
          chk("wr_resp_ack_err",
              {29'h0, s_cpuif_rd_ack, s_cpuif_wr_ack, s_cpuif_wr_err},
              {29'h0, 1'b0, 1'b1, r.err});
        end else begin
          chk("rd_resp_ack_err",
              {29'h0, s_cpuif_rd_ack, s_cpuif_wr_ack, s_cpuif_rd_err},
              {29'h0, 3'b100});
          chk("rd_data", s_cpuif_rd_data, r.data);
        end
      end else begin
        chk("idle_acks", {30'h0, s_cpuif_rd_ack, s_cpuif_wr_ack}, 32'h0);
        chk("idle_rd_data", s_cpuif_rd_data, 32'h0);
      end
    end
  end

  initial begin
    rst               = 1'b1;
    s_cpuif_req       = 1'b0;
    s_cpuif_req_is_wr = 1'b0;
    s_cpuif_addr      = '0;
    s_cpuif_wr_data   = '0;
    s_cpuif_wr_biten  = '0;
    hwif_in_status    = 32'hA5A5_0001;
    hwif_in_cnt_incr  = 1'b0;
    hwif_in_intr_set  = '0;
    tick();
    tick();
    armed = 1'b1;
    rst   = 1'b0;

    chk("rst_ctrl", hwif_out_ctrl, 32'h0);
    chk("rst_cnt", {16'h0, hwif_out_cnt}, 32'h0);
    chk("rst_irq_par", {30'h0, hwif_out_irq, parity_error}, 32'h0);
    chk("stalls", {30'h0, s_cpuif_req_stall_wr, s_cpuif_req_stall_rd},
        32'h0);
    chk("rst_wr_err", {31'h0, s_cpuif_wr_err}, 32'h0);

    rd(4'h0, 32'h0);
    rd(4'h4, 32'hA5A5_0001);
    rd(4'h8, 32'h0);
    rd(4'hC, 32'h0);
    tick();

    wr(4'h0, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0);
    chk("ctrl_biten", hwif_out_ctrl, 32'hDEAD_0000);
    rd(4'h0, 32'hDEAD_0000);
    tick();

    wr(4'h8, 32'h0000_FFFE, 32'hFFFF_FFFF, 1'b0);
    chk("cnt_wr", {16'h0, hwif_out_cnt}, 32'h0000_FFFE);
    hwif_in_cnt_incr = 1'b1;
    tick();
    chk("cnt_inc1", {16'h0, hwif_out_cnt}, 32'h0000_FFFF);
    tick();
    chk("cnt_wrap", {16'h0, hwif_out_cnt}, 32'h0000_0000);
    tick();
    chk("cnt_inc3", {16'h0, hwif_out_cnt}, 32'h0000_0001);
    wr(4'h8, 32'hABCD_0010, 32'hFFFF_FFFF, 1'b0);
    chk("cnt_wr_wins", {16'h0, hwif_out_cnt}, 32'h0000_0010);
    rd(4'h8, 32'h0000_0010);
    chk("cnt_inc_after_rd", {16'h0, hwif_out_cnt}, 32'h0000_0011);
    hwif_in_cnt_incr = 1'b0;
    tick();

    wr(4'h0, 32'h0000_0005, 32'h0000_00FF, 1'b0);
    chk("ctrl_low", hwif_out_ctrl, 32'hDEAD_0005);
    chk("irq_idle", {31'h0, hwif_out_irq}, 32'h0);
    hwif_in_intr_set = 8'h07;
    tick();
    hwif_in_intr_set = 8'h00;
    chk("irq_set", {31'h0, hwif_out_irq}, 32'h1);
    rd(4'hC, 32'h0000_0007);
    wr(4'hC, 32'hFFFF_FF05, 32'hFFFF_FFFF, 1'b0);
    chk("irq_clr", {31'h0, hwif_out_irq}, 32'h0);
    rd(4'hC, 32'h0000_0002);
    hwif_in_intr_set = 8'h02;
    wr(4'hC, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
    hwif_in_intr_set = 8'h00;
    rd(4'hC, 32'h0000_0002);
    wr(4'hC, 32'h0000_00FF, 32'h0000_0000, 1'b0);
    rd(4'hC, 32'h0000_0002);
    wr(4'h0, 32'h0000_0002, 32'h0000_00FF, 1'b0);
    chk("irq_mask", {31'h0, hwif_out_irq}, 32'h1);
    tick();

    wr(4'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    hwif_in_status = 32'h1234_5678;
    rd(4'h4, 32'h1234_5678);
    chk("ctrl_after_status_wr", hwif_out_ctrl, 32'hDEAD_0002);
    chk("par_normal", {31'h0, parity_error}, 32'h0);
    tick();

    rst               = 1'b1;
    s_cpuif_req       = 1'b1;
    s_cpuif_req_is_wr = 1'b0;
    s_cpuif_addr      = 4'h0;
    tick();
    s_cpuif_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_ctrl", hwif_out_ctrl, 32'h0);
    chk("midrst_cnt", {16'h0, hwif_out_cnt}, 32'h0);
    chk("midrst_irq", {31'h0, hwif_out_irq}, 32'h0);
    rd(4'hC, 32'h0);
    rd(4'h8, 32'h0);
    tick();

`ifdef REGBLOCK_PARITYCHECK_EN
    wr(4'h0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);
    hwif_in_cnt_incr = 1'b1;
    hwif_in_intr_set = 8'h81;
    tick();
    hwif_in_cnt_incr = 1'b0;
    hwif_in_intr_set = 8'h00;
    chk("par_traffic", {31'h0, parity_error}, 32'h0);
    force dut.ctrl_q = 32'h0F0F_0F0E;
    #2;
    release dut.ctrl_q;
    chk("par_flip", {31'h0, parity_error}, 32'h1);
    tick();
    chk("par_flip_held", {31'h0, parity_error}, 32'h1);
    wr(4'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    chk("par_rewrite", {31'h0, parity_error}, 32'h0);
`endif

    tick();
    tick();
    tick();
    chk("sb_drain", sbq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regblock_adapter.md
Name: regblock_adapter

Overview:
- Small memory-mapped control/status register block with a 32-bit pass-through CPU interface.
- Hardware-side inputs and outputs are flat vectors.
- Provides one RW control register, one RO status register, a 16-bit SW-writable event counter, and an 8-bit sticky W1C interrupt register with masked IRQ output.
- Sits between a bus bridge (AXI/APB-to-passthrough) and peripheral logic.

Parameters:
- DATA_W, 32, CPU data width; fixed, other values unsupported.
- ADDR_W, 4, CPU byte-address width; 4 word registers.
- CTRL_RESET, 32'h0000_0000, reset value of CTRL.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_cpuif_req  in  1  request strobe, one transfer per cycle high
- s_cpuif_req_is_wr  in  1  1=write, 0=read
- s_cpuif_addr  in  ADDR_W  byte address; bits [1:0] ignored
- s_cpuif_wr_data  in  32  write data
- s_cpuif_wr_biten  in  32  per-bit write enable
- s_cpuif_req_stall_wr  out  1  tied 0
- s_cpuif_req_stall_rd  out  1  tied 0
- s_cpuif_rd_ack  out  1  read response strobe
- s_cpuif_rd_err  out  1  read error, valid with rd_ack
- s_cpuif_rd_data  out  32  read data, valid with rd_ack, else 0
- s_cpuif_wr_ack  out  1  write response strobe
- s_cpuif_wr_err  out  1  write error, valid with wr_ack
- hwif_in_status  in  32  value returned by STATUS reads
- hwif_in_cnt_incr  in  1  counter increment pulse
- hwif_in_intr_set  in  8  interrupt set pulses, per bit
- hwif_out_ctrl  out  32  CTRL storage
- hwif_out_cnt  out  16  counter value
- hwif_out_irq  out  1  |(INTR & CTRL[7:0])
- parity_error  out  1  storage parity mismatch; always 0 when feature disabled

Behaviour:
- Register map (word address = addr[3:2]):
  - 0x0 CTRL: RW, 32 bits.
  - 0x4 STATUS: RO, reads hwif_in_status sampled in request cycle.
  - 0x8 CNT: RW [15:0]; [31:16] read 0.
  - 0xC INTR: [7:0] W1C; [31:8] read 0.
- Reset (rst=1 at clock edge):
  - CTRL=CTRL_RESET, CNT=0, INTR=0.
  - All ack/err/rd_data outputs 0; parity_error=0.
  - No output may be X after the first reset edge.
- Handshake:
  - Request accepted every cycle s_cpuif_req=1; stall outputs constant 0.
  - Response exactly 1 cycle after the request cycle: rd_ack or wr_ack high for 1 cycle.
  - Back-to-back requests give back-to-back acks.
- Writes:
  - Storage bit updates only where wr_biten=1.
  - CTRL/CNT: new = (old & ~biten) | (wr_data & biten).
  - INTR: bit clears where wr_data & biten is 1.
  - Write to STATUS: acked, wr_err=1, no effect.
- Reads: rd_data registered; read of CNT/INTR returns the value before any same-cycle update.
- All addresses in the 4-bit space are mapped, so rd_err=0 on every read.
- Counter:
  - +1 per clock with hwif_in_cnt_incr=1; wraps 0xFFFF->0x0000.
  - SW write in the same cycle wins over increment.
- INTR:
  - Bit n sets when hwif_in_intr_set[n]=1.
  - Set and SW clear in the same cycle: set wins.
- hwif_out_irq is combinational from storage: rises the cycle after the set pulse, falls the cycle after the clearing write.
- Reset asserted mid-transfer: pending response is dropped (no ack), and storage returns to reset values.

Optional Feature:
- Macro: REGBLOCK_PARITYCHECK_EN.
- When defined:
  - One even-parity bit each is stored for CTRL, CNT and INTR, updated on every storage update.
  - parity_error = combinational OR of parity mismatches between each register and its stored parity bit.
  - Normal operation always gives 0; an injected storage bit flip gives 1 until the register is rewritten or reset.
- When undefined: no parity storage; parity_error tied 0.

Test Plan:
- Reset, then read all 4 addresses -> rd_ack 1 cycle after each req; data 0, STATUS value, 0, 0; rd_err=0; hwif_out has no X.
- Write CTRL=0xDEADBEEF with biten=0xFFFF0000, then read -> 0xDEAD0000; hwif_out_ctrl=0xDEAD0000; wr_ack one cycle after req.
- Write CNT=0xFFFE, pulse incr 3 cycles -> hwif_out_cnt 0xFFFF, 0x0000, 0x0001; write 0x0010 during an incr cycle -> 0x0010.
- CTRL[7:0]=0x05, pulse intr_set=0x07 -> INTR reads 0x07, irq=1; write INTR=0x05 -> INTR=0x02, irq=0; simultaneous set bit1 + clear bit1 -> bit1 stays 1.
- Write STATUS -> wr_ack with wr_err=1; hwif_in_status=0x12345678 read back unchanged.
- With REGBLOCK_PARITYCHECK_EN: normal traffic -> parity_error=0; force a CTRL bit flip -> parity_error=1; rewrite CTRL -> 0.
